trap_ctrl: RTL and testbench
============================

# trap_ctrl

Trap and interrupt sequencer for the XYZ core: the initiator side of the CSR file's trap interface. It arbitrates synchronous exceptions, `mret`, and enabled machine interrupts at instruction boundaries, then runs a fixed flush → commit → redirect sequence. During commit it pulses the trap (or `mret`) strobe into the CSR file, and it finally hands the handler or return PC to fetch with a valid/ack handshake.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `flush_o` is held; legal range 1–15.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `exc_valid_i` in 1: synchronous exception reported by execute.
- `exc_cause_i` in 4: exception code.
- `exc_pc_i` in 32: PC of the faulting instruction.
- `exc_tval_i` in 32: trap value.
- `mret_i` in 1: an `mret` is retiring.
- `retire_i` in 1: instruction boundary; interrupts are sampled only here.
- `pc_next_i` in 32: PC of the next instruction; becomes `mepc` for interrupts.
- `int_meip_i`, `int_mtip_i`, `int_msip_i` in 1 each: pending machine external, timer, and software interrupts.
- `mstatus_mie_i`, `mie_meie_i`, `mie_mtie_i`, `mie_msie_i` in 1 each: enables from the CSR file.
- `mtvec_i` in 32: trap vector.
- `mepc_i` in 32: return address.
- `trap_o` out 1: one-cycle trap strobe to the CSR file.
- `trap_interrupt_o` out 1: `mcause[31]`.
- `trap_cause_o` out 4: `mcause` code.
- `trap_pc_o` out 32: value for `mepc`, with bits [1:0] forced to 0.
- `trap_tval_o` out 32: value for `mtval` (0 for interrupts).
- `mret_o` out 1: one-cycle strobe to the CSR file (restore `mie` from `mpie`).
- `flush_o` out 1: kill in-flight pipeline stages.
- `busy_o` out 1: stall fetch/decode; equals state ≠ IDLE.
- `redirect_valid_o` out 1: redirect request to fetch.
- `redirect_pc_o` out 32: target PC.
- `redirect_ack_i` in 1: fetch accepted the redirect.

## Operation
- States: IDLE, FLUSH, COMMIT, REDIRECT.
- **Arbitration in IDLE**, one event accepted per cycle, highest priority first:
  - `exc_valid_i`.
  - `mret_i`.
  - Interrupt, when `retire_i` & `mstatus_mie_i` & any (pending & enabled). Among interrupts: MEI (code 11) > MSI (3) > MTI (7).
- Lower-priority events in the same cycle are dropped. A level interrupt is re-evaluated after return to IDLE.
- **Accept**:
  - Latch kind (exc/mret/int), cause, and interrupt bit.
  - Latch pc: `exc_pc_i` for exceptions, `pc_next_i` for interrupts.
  - Latch tval: `exc_tval_i` for exceptions, 0 otherwise.
  - For mret, latch `mepc_i`.
  - Load the flush counter with `FLUSH_CYCLES`, then go to FLUSH.
- **While busy**, all event inputs are ignored.
- **FLUSH**: `flush_o`=1; the counter decrements each cycle; at 1, go to COMMIT.
- **COMMIT**, one cycle:
  - Trap: `trap_o`=1 with latched cause/interrupt/pc/tval.
  - Mret: `mret_o`=1.
  - Compute the target PC into a register:
    - Trap target = `{mtvec_i[31:2],2'b00}`, with vectoring per Configuration.
    - Mret target = latched `mepc` with bits [1:0] cleared.
  - Go to REDIRECT.
- **REDIRECT**: `redirect_valid_o`=1 and `redirect_pc_o` stable until `redirect_ack_i`. The ack cycle is the last REDIRECT cycle; IDLE follows.
- **Reset values**: every output is 0 and state is IDLE. An asserted `rst_i` mid-sequence aborts immediately; no strobe is emitted after reset.
- **Arithmetic**: target = base + {26'b0, cause, 2'b00}, 32-bit wrap-around with no overflow flag.

## Timing
- Event accepted at edge T, so state=FLUSH from T+1.
- `flush_o`/`busy_o` are high T+1 … T+`FLUSH_CYCLES`.
- COMMIT at T+`FLUSH_CYCLES`+1: `trap_o`/`mret_o` high for exactly that cycle.
- REDIRECT from T+`FLUSH_CYCLES`+2. With ack held high, `busy_o` falls at T+`FLUSH_CYCLES`+3.
- A new event can be accepted in the first IDLE cycle.
- Minimum event-to-event spacing is `FLUSH_CYCLES`+3 cycles.
- All outputs are registered; there is no combinational input-to-output path except none (`redirect_ack_i` only affects next state).

## Configuration
- `TRAP_VECTORED_EN`:
  - Defined: when `mtvec_i[1:0]`==2'b01 and the trap is an interrupt, target = base + 4×cause. Exceptions always use base.
  - Undefined: the mode bits are ignored and all traps go to base (direct mode only).

## Test plan
- **Exception**: `exc_valid_i`=1, cause=2, pc=0x104, tval=0xDEAD, `mtvec_i`=0x200, `FLUSH_CYCLES`=2 → `flush_o` high 2 cycles; then `trap_o` pulse with cause 2, int 0, `trap_pc_o`=0x104, tval 0xDEAD; then `redirect_pc_o`=0x200 until ack.
- **Interrupt priority**: `retire_i`=1, `mstatus_mie_i`=1, all three pending and enabled, `pc_next_i`=0x40 → `trap_cause_o`=11, `trap_interrupt_o`=1, `trap_pc_o`=0x40, tval 0. Repeat with only `int_mtip_i`/`int_msip_i` pending → 3.
- **Vectored**: with `TRAP_VECTORED_EN` defined and `mtvec_i`=0x201, a timer interrupt gives `redirect_pc_o`=0x21C. Without the macro it gives 0x200.
- **Mret**: `mret_i`=1, `mepc_i`=0x87 → `mret_o` pulse with no `trap_o`, and `redirect_pc_o`=0x84.
- **Simultaneous events**: `exc_valid_i`+`mret_i`+pending interrupt in one cycle → only the exception is taken. With `redirect_ack_i` held 0 for 5 cycles, `redirect_valid_o` and PC stay stable and a new exception during that time is ignored.
- **Reset mid-FLUSH**: assert `rst_i` → all outputs 0 asynchronously, no `trap_o` ever emitted, and IDLE after release.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap and interrupt sequencer: arbitrates exceptions, mret and machine interrupts,
// then runs flush -> commit -> redirect. Optional macro TRAP_VECTORED_EN enables vectored interrupts.
module trap_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  input  logic        mret_i,
  input  logic        retire_i,
  input  logic [31:0] pc_next_i,
  input  logic        int_meip_i,
  input  logic        int_mtip_i,
  input  logic        int_msip_i,
  input  logic        mstatus_mie_i,
  input  logic        mie_meie_i,
  input  logic        mie_mtie_i,
  input  logic        mie_msie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        trap_o,
  output logic        trap_interrupt_o,
  output logic [3:0]  trap_cause_o,
  output logic [31:0] trap_pc_o,
  output logic [31:0] trap_tval_o,
  output logic        mret_o,
  output logic        flush_o,
  output logic        busy_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ack_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_e      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        mret_kind_r, int_r;
  logic [3:0]  cause_r;
  logic [31:0] pc_r, tval_r, tgt_r;
  logic        trap_r, mret_r, flush_r, busy_r, rv_r;

  logic        accept_s, acc_mret_s, acc_int_s;
  logic [3:0]  acc_cause_s;
  logic [31:0] acc_pc_s, acc_tval_s;
  logic [2:0]  irq_en_s;
  logic        irq_take_s;
  logic [3:0]  irq_cause_s;
  logic [31:0] base_s, tgt_s;

  // Interrupt priority: MEI (11) > MSI (3) > MTI (7); pend = {mei, msi, mti}
  function automatic logic [3:0] irq_code(input logic [2:0] pend);
    logic [3:0] code;
    code = 4'd0;
    if (pend[2]) begin
      code = 4'd11;
    end else if (pend[1]) begin
      code = 4'd3;
    end else if (pend[0]) begin
      code = 4'd7;
    end else begin
      code = 4'd0;
    end
    return code;
  endfunction

  assign irq_en_s    = {int_meip_i & mie_meie_i, int_msip_i & mie_msie_i, int_mtip_i & mie_mtie_i};
  assign irq_take_s  = retire_i & mstatus_mie_i & (|irq_en_s);
  assign irq_cause_s = irq_code(irq_en_s);
  assign base_s      = mtvec_i & ALIGN_MASK;

  // Next-state and accept decode; events are only looked at in IDLE
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    accept_s    = 1'b0;
    acc_mret_s  = 1'b0;
    acc_int_s   = 1'b0;
    acc_cause_s = 4'd0;
    acc_pc_s    = 32'd0;
    acc_tval_s  = 32'd0;
    case (state_r)
      IDLE: begin
        if (exc_valid_i) begin
          accept_s    = 1'b1;
          acc_cause_s = exc_cause_i;
          acc_pc_s    = exc_pc_i & ALIGN_MASK;
          acc_tval_s  = exc_tval_i;
        end else if (mret_i) begin
          accept_s    = 1'b1;
          acc_mret_s  = 1'b1;
          acc_pc_s    = mepc_i & ALIGN_MASK;
        end else if (irq_take_s) begin
          accept_s    = 1'b1;
          acc_int_s   = 1'b1;
          acc_cause_s = irq_cause_s;
          acc_pc_s    = pc_next_i & ALIGN_MASK;
        end else begin
          accept_s    = 1'b0;
        end
        if (accept_s) begin
          state_s = FLUSH;
          cnt_s   = 4'(FLUSH_CYCLES);
        end else begin
          state_s = IDLE;
        end
      end
      FLUSH: begin
        if (cnt_r <= 4'd1) begin
          state_s = COMMIT;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      COMMIT: state_s = REDIRECT;
      REDIRECT: begin
        if (redirect_ack_i) begin
          state_s = IDLE;
        end else begin
          state_s = REDIRECT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Redirect target: aligned mepc for mret, otherwise mtvec base (optionally vectored)
  always_comb begin
    tgt_s = base_s;
    if (mret_kind_r) begin
      tgt_s = pc_r;
`ifdef TRAP_VECTORED_EN
    end else if (int_r && (mtvec_i[1:0] == 2'b01)) begin
      tgt_s = base_s + {26'd0, cause_r, 2'b00};
`endif
    end else begin
      tgt_s = base_s;
    end
  end

  // State, latched event and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      mret_kind_r <= 1'b0;
      int_r       <= 1'b0;
      cause_r     <= 4'd0;
      pc_r        <= 32'd0;
      tval_r      <= 32'd0;
      tgt_r       <= 32'd0;
      trap_r      <= 1'b0;
      mret_r      <= 1'b0;
      flush_r     <= 1'b0;
      busy_r      <= 1'b0;
      rv_r        <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        mret_kind_r <= acc_mret_s;
        int_r       <= acc_int_s;
        cause_r     <= acc_cause_s;
        pc_r        <= acc_pc_s;
        tval_r      <= acc_tval_s;
      end
      if (state_r == COMMIT) begin
        tgt_r <= tgt_s;
      end
      trap_r  <= (state_s == COMMIT) && !mret_kind_r;
      mret_r  <= (state_s == COMMIT) && mret_kind_r;
      flush_r <= (state_s == FLUSH);
      busy_r  <= (state_s != IDLE);
      rv_r    <= (state_s == REDIRECT);
    end
  end

  assign trap_o           = trap_r;
  assign trap_interrupt_o = int_r;
  assign trap_cause_o     = cause_r;
  assign trap_pc_o        = pc_r;
  assign trap_tval_o      = tval_r;
  assign mret_o           = mret_r;
  assign flush_o          = flush_r;
  assign busy_o           = busy_r;
  assign redirect_valid_o = rv_r;
  assign redirect_pc_o    = tgt_r;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected trap/mret records are queued when an event
// is driven and compared when the strobe and redirect appear.
module tb_trap_ctrl;
  localparam int unsigned FC = 2;
`ifdef TRAP_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        exc_valid_i, mret_i, retire_i;
  logic [3:0]  exc_cause_i;
  logic [31:0] exc_pc_i, exc_tval_i, pc_next_i, mtvec_i, mepc_i;
  logic        int_meip_i, int_mtip_i, int_msip_i;
  logic        mstatus_mie_i, mie_meie_i, mie_mtie_i, mie_msie_i;
  logic        trap_o, trap_interrupt_o, mret_o, flush_o, busy_o, redirect_valid_o;
  logic [3:0]  trap_cause_o;
  logic [31:0] trap_pc_o, trap_tval_o, redirect_pc_o;
  logic        redirect_ack_i;

  typedef struct {
    logic        is_mret;
    logic        is_int;
    logic [3:0]  cause;
    logic [31:0] pc;
    logic [31:0] tval;
    logic [31:0] tgt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] cur_tgt = 32'd0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_trap = 0;

  trap_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
    .mret_i(mret_i), .retire_i(retire_i), .pc_next_i(pc_next_i),
    .int_meip_i(int_meip_i), .int_mtip_i(int_mtip_i), .int_msip_i(int_msip_i),
    .mstatus_mie_i(mstatus_mie_i), .mie_meie_i(mie_meie_i), .mie_mtie_i(mie_mtie_i), .mie_msie_i(mie_msie_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .trap_o(trap_o), .trap_interrupt_o(trap_interrupt_o), .trap_cause_o(trap_cause_o),
    .trap_pc_o(trap_pc_o), .trap_tval_o(trap_tval_o), .mret_o(mret_o),
    .flush_o(flush_o), .busy_o(busy_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o), .redirect_ack_i(redirect_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_target(input logic [31:0] mtvec, input logic is_int, input logic [3:0] cause);
    logic [31:0] b;
    b = {mtvec[31:2], 2'b00};
    if (VEC && is_int && (mtvec[1:0] == 2'b01)) b = b + {26'd0, cause, 2'b00};
    return b;
  endfunction

  // Strobe/redirect monitor against the scoreboard
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (trap_o) n_trap++;
      if (trap_o || mret_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("mret_o", 32'(mret_o), 32'(e.is_mret));
          check("trap_o", 32'(trap_o), 32'(!e.is_mret));
          if (!e.is_mret) begin
            check("trap_int", 32'(trap_interrupt_o), 32'(e.is_int));
            check("trap_cause", 32'(trap_cause_o), 32'(e.cause));
            check("trap_pc", trap_pc_o, e.pc);
            check("trap_tval", trap_tval_o, e.tval);
          end
          cur_tgt = e.tgt;
        end
      end
      if (redirect_valid_o) check("redirect_pc", redirect_pc_o, cur_tgt);
    end
  end

  task automatic clear_events();
    exc_valid_i = 1'b0; mret_i = 1'b0; retire_i = 1'b0;
    int_meip_i = 1'b0; int_mtip_i = 1'b0; int_msip_i = 1'b0;
  endtask

  // Caller sets event inputs just after a negedge; this runs the whole sequence
  task automatic fire(input int ack_delay, input logic inject);
    exp_t e;
    logic  take;
    int    n;
    take = 1'b1;
    e.is_mret = 1'b0; e.is_int = 1'b0; e.cause = 4'd0; e.tval = 32'd0; e.pc = 32'd0;
    if (exc_valid_i) begin
      e.cause = exc_cause_i; e.pc = {exc_pc_i[31:2], 2'b00}; e.tval = exc_tval_i;
      e.tgt = exp_target(mtvec_i, 1'b0, e.cause);
    end else if (mret_i) begin
      e.is_mret = 1'b1; e.pc = {mepc_i[31:2], 2'b00}; e.tgt = e.pc;
    end else if (retire_i && mstatus_mie_i &&
                 ((int_meip_i && mie_meie_i) || (int_msip_i && mie_msie_i) || (int_mtip_i && mie_mtie_i))) begin
      e.is_int = 1'b1; e.pc = {pc_next_i[31:2], 2'b00};
      e.cause = (int_meip_i && mie_meie_i) ? 4'd11 : (int_msip_i && mie_msie_i) ? 4'd3 : 4'd7;
      e.tgt = exp_target(mtvec_i, 1'b1, e.cause);
    end else begin
      take = 1'b0; e.tgt = 32'd0;
    end
    if (take) sb_q.push_back(e);
    @(negedge clk_i);
    clear_events();
    if (!take) begin
      repeat (3) begin
        check("idle_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
      end
      return;
    end
    check("flush_start", 32'(flush_o), 32'd1);
    n = 0;
    while (flush_o && n < 20) begin
      check("busy_flush", 32'(busy_o), 32'd1);
      n++;
      @(negedge clk_i);
    end
    check("flush_len", 32'(n), 32'(FC));
    check("strobe", 32'(trap_o | mret_o), 32'd1);
    @(negedge clk_i);
    for (int i = 0; i < ack_delay; i++) begin
      if (inject) begin
        exc_valid_i = 1'b1; exc_cause_i = 4'd5; exc_pc_i = 32'h500;
      end
      check("rv_hold", 32'(redirect_valid_o), 32'd1);
      @(negedge clk_i);
    end
    exc_valid_i = 1'b0;
    check("rv_ack", 32'(redirect_valid_o), 32'd1);
    redirect_ack_i = 1'b1;
    @(negedge clk_i);
    redirect_ack_i = 1'b0;
    check("busy_after", 32'(busy_o), 32'd0);
    check("rv_after", 32'(redirect_valid_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    rst_i = 1'b1; redirect_ack_i = 1'b0;
    clear_events();
    exc_cause_i = 4'd0; exc_pc_i = 32'd0; exc_tval_i = 32'd0; pc_next_i = 32'd0;
    mtvec_i = 32'h200; mepc_i = 32'd0;
    mstatus_mie_i = 1'b1; mie_meie_i = 1'b1; mie_mtie_i = 1'b1; mie_msie_i = 1'b1;
    #1;
    check("reset_outs", 32'(|{trap_o, trap_interrupt_o, trap_cause_o, trap_pc_o, trap_tval_o, mret_o,
                              flush_o, busy_o, redirect_valid_o, redirect_pc_o}), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    exc_valid_i = 1'b1; exc_cause_i = 4'd2; exc_pc_i = 32'h104; exc_tval_i = 32'hDEAD;
    fire(2, 1'b0);
    exc_valid_i = 1'b1; exc_cause_i = 4'd4; exc_pc_i = 32'h107; exc_tval_i = 32'h1234_5678;
    fire(0, 1'b0);

    retire_i = 1'b1; pc_next_i = 32'h40; int_meip_i = 1'b1; int_mtip_i = 1'b1; int_msip_i = 1'b1;
    fire(1, 1'b0);
    retire_i = 1'b1; pc_next_i = 32'h40; int_mtip_i = 1'b1; int_msip_i = 1'b1;
    fire(1, 1'b0);
    mtvec_i = 32'h201; retire_i = 1'b1; pc_next_i = 32'h80; int_mtip_i = 1'b1;
    fire(1, 1'b0);
    mtvec_i = 32'hFFFF_FFFD; retire_i = 1'b1; pc_next_i = 32'h90; int_meip_i = 1'b1;
    fire(0, 1'b0);
    exc_valid_i = 1'b1; exc_cause_i = 4'd3; exc_pc_i = 32'h60; exc_tval_i = 32'd0;
    fire(0, 1'b0);
    mtvec_i = 32'h200;

    mret_i = 1'b1; mepc_i = 32'h87;
    fire(1, 1'b0);

    exc_valid_i = 1'b1; exc_cause_i = 4'd1; exc_pc_i = 32'h300; exc_tval_i = 32'hBEEF;
    mret_i = 1'b1; retire_i = 1'b1; int_meip_i = 1'b1;
    fire(5, 1'b1);

    retire_i = 1'b0; int_meip_i = 1'b1;
    fire(0, 1'b0);
    retire_i = 1'b1; int_meip_i = 1'b1; mstatus_mie_i = 1'b0;
    fire(0, 1'b0);
    mstatus_mie_i = 1'b1;
    retire_i = 1'b1; int_msip_i = 1'b1; mie_msie_i = 1'b0;
    fire(0, 1'b0);
    mie_msie_i = 1'b1;

    t0 = n_trap;
    exc_valid_i = 1'b1; exc_cause_i = 4'd6; exc_pc_i = 32'h700; exc_tval_i = 32'h1;
    @(negedge clk_i);
    clear_events();
    check("rst_pre_flush", 32'(flush_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_async_outs", 32'(|{trap_o, trap_interrupt_o, trap_cause_o, trap_pc_o, trap_tval_o, mret_o,
                                  flush_o, busy_o, redirect_valid_o, redirect_pc_o}), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (8) @(negedge clk_i);
    check("rst_no_trap", 32'(n_trap), 32'(t0));
    check("rst_idle", 32'(busy_o), 32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
